ctrl_core_seq: RTL and testbench

- Parametrised successor to the bin-level Sat Engine controller.
- Sequences BCP -> decision -> conflict analysis -> in-bin backtrack for one loaded bin, and reports a multi-valued termination status instead of plain sat/unsat.
- Adds three termination causes: conflict budget, per-phase watchdog timeout, external abort.
- Adds direct global-UNSAT detection on a level-0 conflict, statistics counters, and strict one-cycle request pulses.

---
 rtl/ctrl_core_seq.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_core_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_core_seq.sv
// Bin-level SAT engine controller: sequences BCP, decision, analysis and
// in-bin backtrack, ending with a multi-valued termination status.
module ctrl_core_seq #(
  parameter int WIDTH_LVL      = 16,
  parameter int WIDTH_CNT      = 32,
  parameter int MAX_CONFLICTS  = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WIDTH_TO       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_core_i,
  input  logic                 abort_i,
  output logic                 done_core_o,
  output logic [2:0]           status_o,
  output logic                 sat_o,
  output logic                 unsat_o,
  output logic                 apply_imply_o,
  input  logic                 done_imply_i,
  input  logic                 conflict_i,
  output logic                 start_decision_o,
  input  logic                 done_decision_i,
  input  logic                 all_c_is_sat_i,
  input  logic [WIDTH_LVL-1:0] cur_lvl_i,
  output logic                 apply_analyze_o,
  input  logic                 done_analyze_i,
  input  logic [WIDTH_LVL-1:0] bkt_bin_num_i,
  input  logic [WIDTH_LVL-1:0] cur_bin_num_i,
  output logic                 apply_bkt_cur_bin_o,
  input  logic                 done_bkt_cur_bin_i,
  output logic [WIDTH_CNT-1:0] conflict_cnt_o,
  output logic [WIDTH_CNT-1:0] decision_cnt_o
);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_SAT     = 3'd1;
  localparam logic [2:0] ST_UNS_BKT = 3'd2;
  localparam logic [2:0] ST_UNS_GLB = 3'd3;
  localparam logic [2:0] ST_BUDGET  = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;
  localparam logic [2:0] ST_ABORT   = 3'd6;

  localparam logic [WIDTH_CNT-1:0] MAXC =
    WIDTH_CNT'(MAX_CONFLICTS);
  localparam logic [WIDTH_TO-1:0] TO_LAST =
    WIDTH_TO'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    BCP,
    DECISION,
    ANALYSIS,
    BKT_CUR_BIN,
    FINISH
  } state_t;

  state_t               state, state_nx;
  logic                 first;
  logic [2:0]           status_q, status_nx;
  logic [WIDTH_CNT-1:0] ccnt, ccnt_nx, ccnt_inc;
  logic [WIDTH_CNT-1:0] dcnt, dcnt_nx, dcnt_inc;
  logic [WIDTH_TO-1:0]  wd, wd_nx;
  logic                 phase, done_sel, done_ok;
  logic                 to_hit, budget_hit;

  assign ccnt_inc = (&ccnt) ? ccnt : ccnt + 1'b1;
  assign dcnt_inc = (&dcnt) ? dcnt : dcnt + 1'b1;

  assign phase = (state == BCP) || (state == DECISION) ||
                 (state == ANALYSIS) || (state == BKT_CUR_BIN);

  always_comb begin
    done_sel = 1'b0;
    unique case (state)
      BCP:         done_sel = done_imply_i;
      DECISION:    done_sel = done_decision_i;
      ANALYSIS:    done_sel = done_analyze_i;
      BKT_CUR_BIN: done_sel = done_bkt_cur_bin_i;
      default:     done_sel = 1'b0;
    endcase
  end

  // the first cycle of a phase is the request cycle; its done is stale
  assign done_ok    = done_sel && !first;
  assign to_hit     = (TIMEOUT_CYCLES != 0) && (wd >= TO_LAST);
  assign budget_hit = (MAX_CONFLICTS != 0) && (ccnt_inc >= MAXC);

  always_comb begin
    state_nx  = state;
    status_nx = status_q;
    ccnt_nx   = ccnt;
    dcnt_nx   = dcnt;
    wd_nx     = wd + 1'b1;
    unique case (state)
      IDLE: begin
        if (start_core_i) begin
          state_nx  = BCP;
          status_nx = ST_NONE;
          ccnt_nx   = '0;
          dcnt_nx   = '0;
        end
      end
      BCP: begin
        if (done_ok) begin
          if (conflict_i) begin
            ccnt_nx = ccnt_inc;
            if (cur_lvl_i == '0) begin
              state_nx  = FINISH;
              status_nx = ST_UNS_GLB;
            end else if (budget_hit) begin
              state_nx  = FINISH;
              status_nx = ST_BUDGET;
            end else begin
              state_nx = ANALYSIS;
            end
          end else begin
            state_nx = DECISION;
          end
        end
      end
      DECISION: begin
        if (first) dcnt_nx = dcnt_inc;
        if (done_ok) begin
          if (all_c_is_sat_i) begin
            state_nx  = FINISH;
            status_nx = ST_SAT;
          end else begin
            state_nx = BCP;
          end
        end
      end
      ANALYSIS: begin
        if (done_ok) begin
          if (bkt_bin_num_i != cur_bin_num_i) begin
            state_nx  = FINISH;
            status_nx = ST_UNS_BKT;
          end else begin
            state_nx = BKT_CUR_BIN;
          end
        end
      end
      BKT_CUR_BIN: begin
        if (done_ok) state_nx = DECISION;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (phase && !done_ok && to_hit) begin
      state_nx  = FINISH;
      status_nx = ST_TIMEOUT;
    end
    // abort preempts any same-cycle result, including its conflict count
    if (phase && abort_i) begin
      state_nx  = FINISH;
      status_nx = ST_ABORT;
      ccnt_nx   = ccnt;
    end
    if (state_nx != state) wd_nx = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      first    <= 1'b0;
      status_q <= ST_NONE;
      ccnt     <= '0;
      dcnt     <= '0;
      wd       <= '0;
    end else begin
      state    <= state_nx;
      first    <= (state_nx != state);
      status_q <= status_nx;
      ccnt     <= ccnt_nx;
      dcnt     <= dcnt_nx;
      wd       <= wd_nx;
    end
  end

  assign apply_imply_o       = (state == BCP) && first;
  assign start_decision_o    = (state == DECISION) && first;
  assign apply_analyze_o     = (state == ANALYSIS) && first;
  assign apply_bkt_cur_bin_o = (state == BKT_CUR_BIN) && first;
  assign done_core_o         = (state == FINISH);
  assign status_o            = status_q;
  assign sat_o               = (status_q == ST_SAT);
  assign unsat_o             = (status_q == ST_UNS_BKT) ||
                               (status_q == ST_UNS_GLB);
  assign conflict_cnt_o      = ccnt;
  assign decision_cnt_o      = dcnt;

endmodule

// File: tb/tb_ctrl_core_seq.sv
// Scoreboard bench for ctrl_core_seq: a reactive driver answers requests
// and predicts each run's outcome; a monitor checks every done_core_o.
module tb_ctrl_core_seq;

  localparam int MAXC = 3;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_core_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        done_core_o;
  logic [2:0]  status_o;
  logic        sat_o, unsat_o;
  logic        apply_imply_o;
  logic        done_imply_i = 1'b0;
  logic        conflict_i = 1'b0;
  logic        start_decision_o;
  logic        done_decision_i = 1'b0;
  logic        all_c_is_sat_i = 1'b0;
  logic [15:0] cur_lvl_i = '0;
  logic        apply_analyze_o;
  logic        done_analyze_i = 1'b0;
  logic [15:0] bkt_bin_num_i = '0;
  logic [15:0] cur_bin_num_i = '0;
  logic        apply_bkt_cur_bin_o;
  logic        done_bkt_cur_bin_i = 1'b0;
  logic [31:0] conflict_cnt_o, decision_cnt_o;

  ctrl_core_seq #(
    .WIDTH_LVL(16), .WIDTH_CNT(32), .MAX_CONFLICTS(MAXC),
    .TIMEOUT_CYCLES(TO), .WIDTH_TO(16)
  ) dut (
    .clk(clk), .rst(rst),
    .start_core_i(start_core_i), .abort_i(abort_i),
    .done_core_o(done_core_o), .status_o(status_o),
    .sat_o(sat_o), .unsat_o(unsat_o),
    .apply_imply_o(apply_imply_o), .done_imply_i(done_imply_i),
    .conflict_i(conflict_i),
    .start_decision_o(start_decision_o),
    .done_decision_i(done_decision_i),
    .all_c_is_sat_i(all_c_is_sat_i), .cur_lvl_i(cur_lvl_i),
    .apply_analyze_o(apply_analyze_o),
    .done_analyze_i(done_analyze_i),
    .bkt_bin_num_i(bkt_bin_num_i), .cur_bin_num_i(cur_bin_num_i),
    .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o),
    .done_bkt_cur_bin_i(done_bkt_cur_bin_i),
    .conflict_cnt_o(conflict_cnt_o), .decision_cnt_o(decision_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cc;
    logic [31:0] dc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned ccnt, dcnt;
  int          ph;
  bit          ended, ok, fin_seen;
  logic [2:0]  last_st;
  int          n_an = 0;
  logic [3:0]  prev_req = '0;
  logic [3:0]  cur_req;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done_core_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("status", status_o, e.st);
        chk("sat", sat_o, e.st == 3'd1);
        chk("unsat", unsat_o, (e.st == 3'd2) || (e.st == 3'd3));
        chk("conflict_cnt", conflict_cnt_o, e.cc);
        chk("decision_cnt", decision_cnt_o, e.dc);
      end
    end
  end

  always @(negedge clk) begin
    cur_req = {apply_imply_o, start_decision_o,
               apply_analyze_o, apply_bkt_cur_bin_o};
    if (rst && cur_req != 4'd0)
      chk("pulse_width", cur_req & prev_req, 0);
    if (apply_analyze_o) n_an++;
    prev_req = cur_req;
  end

  function automatic logic req(input int p);
    case (p)
      0:       return apply_imply_o;
      1:       return start_decision_o;
      2:       return apply_analyze_o;
      default: return apply_bkt_cur_bin_o;
    endcase
  endfunction

  task automatic push_exp(input logic [2:0] st);
    exp_t e;
    e.st = st;
    e.cc = ccnt;
    e.dc = dcnt;
    exp_q.push_back(e);
    last_st = st;
    ended = 1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start_core_i = 1;
    @(posedge clk);
    #1 start_core_i = 0;
    ccnt = 0;
    dcnt = 0;
    ended = 0;
    fin_seen = 0;
    ok = 1;
    ph = 0;
  endtask

  task automatic wait_req();
    bit got;
    got = 0;
    for (int i = 0; i < 24 && !got; i++) begin
      @(negedge clk);
      got = req(ph);
    end
    chk("req_seen", got, 1);
    ok = got;
    if (!got) ended = 1;
    if (got && ph == 1) dcnt++;
  endtask

  task automatic resp_bcp(input int d, input bit cf, input int lvl);
    repeat (d) @(negedge clk);
    conflict_i = cf;
    cur_lvl_i = 16'(lvl);
    done_imply_i = 1;
    if (cf) begin
      if (ccnt != 32'hffff_ffff) ccnt++;
      if (lvl == 0) push_exp(3'd3);
      else if (MAXC != 0 && ccnt >= MAXC) push_exp(3'd4);
      else ph = 2;
    end else begin
      ph = 1;
    end
    @(posedge clk);
    #1 done_imply_i = 0;
    conflict_i = 0;
  endtask

  task automatic resp_dec(input int d, input bit s);
    repeat (d) @(negedge clk);
    all_c_is_sat_i = s;
    done_decision_i = 1;
    if (s) push_exp(3'd1);
    else ph = 0;
    @(posedge clk);
    #1 done_decision_i = 0;
    all_c_is_sat_i = 0;
  endtask

  task automatic resp_an(input int d, input int bkt, input int cur);
    repeat (d) @(negedge clk);
    bkt_bin_num_i = 16'(bkt);
    cur_bin_num_i = 16'(cur);
    done_analyze_i = 1;
    if (bkt != cur) push_exp(3'd2);
    else ph = 3;
    @(posedge clk);
    #1 done_analyze_i = 0;
  endtask

  task automatic resp_bkt(input int d);
    repeat (d) @(negedge clk);
    done_bkt_cur_bin_i = 1;
    ph = 1;
    @(posedge clk);
    #1 done_bkt_cur_bin_i = 0;
  endtask

  task automatic do_abort(input int d, input bit with_done);
    repeat (d) @(negedge clk);
    abort_i = 1;
    if (with_done) begin
      done_imply_i = 1;
      conflict_i = 0;
    end
    push_exp(3'd6);
    @(posedge clk);
    #1 abort_i = 0;
    done_imply_i = 0;
  endtask

  // called at the negedge where the request pulse was seen
  task automatic do_timeout();
    push_exp(3'd5);
    repeat (TO - 1) @(negedge clk);
    chk("timeout_early", done_core_o, 0);
    @(negedge clk);
    chk("timeout_edge", done_core_o, 1);
    fin_seen = 1;
  endtask

  task automatic finish_wait();
    bit got;
    got = fin_seen;
    for (int i = 0; i < 24 && !got; i++) begin
      @(negedge clk);
      got = done_core_o;
    end
    chk("finish_seen", got, 1);
    @(negedge clk);
    chk("done_one_cycle", done_core_o, 0);
    chk("status_hold", status_o, last_st);
  endtask

  task automatic rand_run();
    int r, cur;
    do_start();
    while (!ended) begin
      wait_req();
      if (!ok) break;
      r = $urandom_range(0, 29);
      if (r == 0) begin
        do_abort($urandom_range(1, 7), 0);
      end else if (r == 1) begin
        do_timeout();
      end else begin
        case (ph)
          0: resp_bcp($urandom_range(1, 7), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4));
          1: resp_dec($urandom_range(1, 7), $urandom_range(0, 3) == 0);
          2: begin
            cur = $urandom_range(0, 7);
            resp_an($urandom_range(1, 7),
                    ($urandom_range(0, 3) == 0) ? (cur ^ 1) : cur, cur);
          end
          default: resp_bkt($urandom_range(1, 7));
        endcase
      end
    end
    if (ok) begin
      finish_wait();
    end else begin
      rst = 0;
      @(negedge clk);
      rst = 1;
      exp_q.delete();
    end
  endtask

  initial begin
    int an0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {done_core_o, status_o, sat_o, unsat_o,
        apply_imply_o, start_decision_o, apply_analyze_o,
        apply_bkt_cur_bin_o}, 0);
    chk("rst_cnts", {conflict_cnt_o, decision_cnt_o}, 0);
    rst = 1;

    // plain SAT run
    do_start();
    wait_req(); resp_bcp(2, 0, 3);
    wait_req(); resp_dec(3, 1);
    finish_wait();

    // in-bin backtrack, done on the last watchdog cycle
    do_start();
    wait_req(); resp_bcp(1, 1, 3);
    wait_req(); resp_an(2, 5, 5);
    wait_req(); resp_bkt(1);
    wait_req(); resp_dec(TO - 1, 1);
    finish_wait();

    // backtrack target in another bin
    do_start();
    wait_req(); resp_bcp(1, 1, 3);
    wait_req(); resp_an(2, 2, 5);
    finish_wait();

    // level-0 conflict skips analysis
    an0 = n_an;
    do_start();
    wait_req(); resp_bcp(3, 1, 0);
    finish_wait();
    chk("no_analyze", n_an - an0, 0);

    // conflict budget
    do_start();
    for (int i = 0; i < MAXC && !ended; i++) begin
      wait_req(); resp_bcp(1, 1, 4);
      if (ended) break;
      wait_req(); resp_an(1, 3, 3);
      wait_req(); resp_bkt(1);
      wait_req(); resp_dec(1, 0);
    end
    finish_wait();

    // decision watchdog
    do_start();
    wait_req(); resp_bcp(1, 0, 1);
    wait_req(); do_timeout();
    finish_wait();

    // abort together with a BCP done
    do_start();
    wait_req(); do_abort(2, 1);
    finish_wait();

    // second start mid-run is ignored
    do_start();
    wait_req(); resp_bcp(1, 0, 1);
    wait_req();
    @(negedge clk);
    start_core_i = 1;
    @(posedge clk);
    #1 start_core_i = 0;
    resp_dec(2, 1);
    finish_wait();

    // done during the request cycle must not be consumed
    do_start();
    wait_req();
    done_imply_i = 1;
    conflict_i = 1;
    cur_lvl_i = '0;
    @(posedge clk);
    #1 done_imply_i = 0;
    conflict_i = 0;
    resp_bcp(2, 0, 1);
    wait_req(); resp_dec(1, 1);
    finish_wait();

    // asynchronous reset during analysis
    do_start();
    wait_req(); resp_bcp(1, 1, 2);
    wait_req();
    #2 rst = 0;
    #1;
    chk("async_rst", {done_core_o, status_o, sat_o, unsat_o,
        apply_imply_o, start_decision_o, apply_analyze_o,
        apply_bkt_cur_bin_o, conflict_cnt_o, decision_cnt_o}, 0);
    @(negedge clk);
    rst = 1;
    begin
      logic [4:0] seen;
      seen = '0;
      repeat (12) begin
        @(negedge clk);
        seen |= {apply_imply_o, start_decision_o, apply_analyze_o,
                 apply_bkt_cur_bin_o, done_core_o};
      end
      chk("quiet_after_rst", seen, 0);
    end

    for (int k = 0; k < 60; k++) rand_run();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
